// File: rtl/mem_access_arbiter.sv
// Two-port (instruction fetch / data) arbiter for a single slow unified memory: IDLE -> ACCESS x LATENCY -> DONE.
// Default is fixed D-priority; define MEM_ARB_RR_EN for round-robin between IF and D on conflicts.
module mem_access_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        win_q, win_d;          // 1 = D port owns the access
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_done_q, if_done_d;
  logic        d_done_q, d_done_d;
  logic        busy_q, busy_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic        d_wins;
  logic        acc_next;
`ifdef MEM_ARB_RR_EN
  logic        last_d_q, last_d_d;
`endif

  always_comb begin
`ifdef MEM_ARB_RR_EN
    // On a conflict the port that did not win last time goes first.
    d_wins = d_req & (~if_req | ~last_d_q);
`else
    d_wins = d_req;
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    win_d      = win_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d_d   = last_d_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          state_d = S_ACCESS;
          win_d   = d_wins;
          we_d    = d_wins & d_we;
          addr_d  = d_wins ? d_addr : if_addr;
          wdata_d = d_wins ? d_wdata : 32'h0;
          cnt_d   = CNT_INIT;
`ifdef MEM_ARB_RR_EN
          last_d_d = d_wins;
`endif
        end
      end
      S_ACCESS: begin
        if (cnt_q == 8'd0) begin
          state_d = S_DONE;
          if (!we_q) begin
            if (win_q) d_rdata_d = mem_dout;
            else       if_rdata_d = mem_dout;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered by deriving them from the next-state values.
    acc_next    = (state_d == S_ACCESS);
    mem_read_d  = acc_next & ~we_d;
    mem_write_d = acc_next & we_d & (cnt_d == 8'd0);
    mem_addr_d  = acc_next ? addr_d : 32'h0;
    mem_din_d   = acc_next ? wdata_d : 32'h0;
    busy_d      = (state_d != S_IDLE);
    if_done_d   = (state_d == S_DONE) & ~win_d;
    d_done_d    = (state_d == S_DONE) & win_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_din_q   <= 32'h0;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      busy_q      <= busy_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  // Memory strobes are forced low for the whole reset cycle so an aborted store never writes.
  assign mem_read  = mem_read_q & ~reset;
  assign mem_write = mem_write_q & ~reset;
  assign mem_addr  = reset ? 32'h0 : mem_addr_q;
  assign mem_din   = reset ? 32'h0 : mem_din_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign busy      = busy_q;

endmodule
